// File: rtl/mod5959_counter.sv
// mod5959_counter: free-running BCD minutes:seconds counter, 00:00 .. 59:59.
// One step per rising clock edge, wrapping to 00:00 after 3600 edges.
// Outputs come straight from the digit registers.
module mod5959_counter (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic [3:0] q4
);

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    logic [3:0] q1_q, q1_d;
    logic [3:0] q2_q, q2_d;
    logic [3:0] q3_q, q3_d;
    logic [3:0] q4_q, q4_d;

    logic carry1;
    logic carry2;
    logic carry3;

    // Next digit values with a same-edge ripple carry chain.
    // A digit above its limit clears on the next edge regardless of incoming
    // carry and passes a carry onward, so any corrupted state settles quickly.
    always_comb begin
        q1_d   = q1_q;
        q2_d   = q2_q;
        q3_d   = q3_q;
        q4_d   = q4_q;
        carry1 = 1'b0;
        carry2 = 1'b0;
        carry3 = 1'b0;

        // seconds units: always advances
        if (q1_q >= UNITS_MAX) begin
            q1_d   = '0;
            carry1 = 1'b1;
        end else begin
            q1_d = q1_q + 4'd1;
        end

        // seconds tens
        if (q2_q > TENS_MAX) begin
            q2_d   = '0;
            carry2 = 1'b1;
        end else if (carry1) begin
            if (q2_q == TENS_MAX) begin
                q2_d   = '0;
                carry2 = 1'b1;
            end else begin
                q2_d = q2_q + 4'd1;
            end
        end

        // minutes units
        if (q3_q > UNITS_MAX) begin
            q3_d   = '0;
            carry3 = 1'b1;
        end else if (carry2) begin
            if (q3_q == UNITS_MAX) begin
                q3_d   = '0;
                carry3 = 1'b1;
            end else begin
                q3_d = q3_q + 4'd1;
            end
        end

        // minutes tens: carry out of this digit is the full-period wrap
        if (q4_q > TENS_MAX) begin
            q4_d = '0;
        end else if (carry3) begin
            if (q4_q == TENS_MAX) begin
                q4_d = '0;
            end else begin
                q4_d = q4_q + 4'd1;
            end
        end
    end

    // Digit registers; synchronous reset takes priority over counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            q1_q <= '0;
            q2_q <= '0;
            q3_q <= '0;
            q4_q <= '0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
            q3_q <= q3_d;
            q4_q <= q4_d;
        end
    end

    assign q1 = q1_q;
    assign q2 = q2_q;
    assign q3 = q3_q;
    assign q4 = q4_q;

endmodule

// File: tb/tb_mod5959_counter.sv
// Testbench for mod5959_counter: directed milestones plus a randomized
// reset-pulse run compared against an elapsed-seconds reference model.
module tb_mod5959_counter;

    logic       clock;
    logic       reset;
    logic [3:0] q1, q2, q3, q4;

    int unsigned n_checks;
    int unsigned n_fails;
    int unsigned model_n;   // seconds since last reset, mod 3600

    mod5959_counter dut (
        .clock (clock),
        .reset (reset),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .q4    (q4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected display value as 16-bit BCD mm:ss from a plain seconds count.
    function automatic logic [15:0] bcd_of(input int unsigned secs);
        int unsigned m, s;
        logic [15:0] r;
        m = (secs % 3600) / 60;
        s = secs % 60;
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(s / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [15:0] dut_val();
        return {q4, q3, q2, q1};
    endfunction

    // One rising edge; the model follows the reset level seen at that edge,
    // then outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        if (reset) model_n = 0;
        else       model_n = (model_n + 1) % 3600;
        #1;
    endtask

    task automatic check_model(input string tag);
        check(tag, dut_val(), bcd_of(model_n));
        check("lim_q1", (q1 <= 4'd9) ? 1 : 0, 1);
        check("lim_q2", (q2 <= 4'd5) ? 1 : 0, 1);
        check("lim_q3", (q3 <= 4'd9) ? 1 : 0, 1);
        check("lim_q4", (q4 <= 4'd5) ? 1 : 0, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_n  = 0;
        reset    = 1'b1;

        // reset state and hold
        tick();
        check("reset", dut_val(), 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_hold", dut_val(), 16'h0000);
        end

        // count from reset through one full wrap
        reset = 1'b0;
        for (int unsigned e = 1; e <= 3601; e++) begin
            tick();
            check_model("run");
            case (e)
                9:    check("e9",    dut_val(), 16'h0009);
                10:   check("e10",   dut_val(), 16'h0010);
                59:   check("e59",   dut_val(), 16'h0059);
                60:   check("e60",   dut_val(), 16'h0100);
                600:  check("e600",  dut_val(), 16'h1000);
                3599: check("e3599", dut_val(), 16'h5959);
                3600: check("e3600", dut_val(), 16'h0000);
                3601: check("e3601", dut_val(), 16'h0001);
                default: ;
            endcase
        end

        // mid-count reset at 12:34
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 754; i++) tick();
        check("at_1234", dut_val(), 16'h1234);
        reset = 1'b1;
        #2;
        check("rst_between_edges", dut_val(), 16'h1234);
        tick();
        check("rst_mid", dut_val(), 16'h0000);
        reset = 1'b0;
        tick();
        check("after_rst", dut_val(), 16'h0001);

        // randomized run with occasional reset pulses
        for (int i = 0; i < 7200; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            tick();
            check_model("rand");
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
